semaforo_sched: RTL and testbench
=================================

# semaforo_sched

Phase scheduler for the two-road intersection with pedestrian crossing. It sequences road A green/yellow, all-red, road B green/yellow, all-red, and an inserted pedestrian WALK phase. All timing comes from the 1 Hz enable from the clock divider. It sits between the board inputs (switches, push button) and the light/HEX display logic in the semaforo top level.

## Interface
Parameters:
- ALLRED_T, 1, all-red duration in ticks (1..15)
- WALK_T, 5, pedestrian WALK duration in ticks (1..15)
- MIN_GREEN, 3, green remaining after a pedestrian request shortens a green (1..15)

Ports:
- clk  in  1  system clock; one clock for the whole block
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle enable pulse at 1 Hz from clkdiv
- ped_btn  in  1  pedestrian button, active-high level, already synchronized
- green_a  in  4  road A green duration in ticks; 0 is treated as 1
- green_b  in  4  road B green duration in ticks; 0 is treated as 1
- yellow_t  in  3  yellow duration in ticks; 0 is treated as 1
- light_a  out  3  road A lamps {red, yellow, green}, one-hot
- light_b  out  3  road B lamps {red, yellow, green}, one-hot
- walk  out  1  pedestrian WALK lamp
- ped_pending  out  1  pedestrian request latched, not yet served
- phase  out  3  current state encoding, for display
- count  out  4  ticks remaining in the current phase, for HEX display

## Operation
States and encodings:
- A_G=0
- A_Y=1
- AR_AB=2
- B_G=3
- B_Y=4
- AR_BA=5
- WALK=6
- Encoding 7 is unused. If the state register holds 7, the next state is AR_BA with count=ALLRED_T.

Sequence:
- A_G → A_Y → AR_AB
- AR_AB → WALK if ped_pending, otherwise → B_G
- B_G → B_Y → AR_BA
- AR_BA → WALK if ped_pending, otherwise → A_G
- WALK → the green of the road not served last. A one-bit next_road register is set in AR_AB to B and in AR_BA to A.

Counting:
- count is loaded on every state entry with that state's duration: green_a/green_b/yellow_t (0→1), ALLRED_T, or WALK_T.
- Switch values are sampled only at entry; changing them mid-phase has no effect until the next entry.
- A transition fires on a cycle where tick=1 and count==1. Otherwise, tick decrements count. count never reaches 0.

Lamps:
- A_G: light_a=001
- A_Y: light_a=010
- All other states: light_a=100
- light_b is the mirror for B_G/B_Y.
- walk=1 only in WALK. Both roads are red in AR_AB, AR_BA and WALK.

Pedestrian request:
- A rising edge of ped_btn (registered previous value) sets ped_pending.
- ped_pending clears on the cycle WALK is entered.
- An edge arriving in the same cycle as WALK entry, or any edge while in WALK, is ignored.

Green shortening:
- Applies to a rising edge in A_G or B_G while count > MIN_GREEN.
- count is loaded with MIN_GREEN on the next edge. This takes priority over a tick decrement in the same cycle.
- If count ≤ MIN_GREEN, count is unchanged.

## Timing
- Reset: state=AR_BA, count=ALLRED_T, next_road=A, ped_pending=0, previous-button register=0.
- Reset outputs: light_a=100, light_b=100, walk=0, phase=5.
- rst mid-phase returns the block to these values on the next edge, discarding any pending request.
- All state, count and ped_pending outputs are registered. Lamps and phase decode from the state register only, with no input-to-output combinational path.
- Phase length is exactly N ticks after entry. The state changes one clk after the tick on which count==1.
- ped_pending rises one clk after the cycle where ped_btn=1 and its previous value=0.
- tick held high for multiple cycles is not supported. Each high cycle counts as one tick.

## Structure
- Shared package semaforo_pkg holds the state encodings, the lamp constants (RED=3'b100, YEL=3'b010, GRN=3'b001), and the default durations.
- One natural sub-module, semaforo_timer: a 4-bit loadable down-counter with load, load_val, en(tick) and a last (count==1) output. Load has priority over en.
- The FSM, request latch and next_road register stay in semaforo_sched.

## Test plan
- Reset then idle, with green_a=4, green_b=6, yellow_t=2, no button:
  - phase sequence 5,0,1,2,3,4,5 with durations 1,4,2,1,6,2,1 ticks.
  - light_a=001 only in phase 0.
- Button rising edge during A_G with count=4, MIN_GREEN=3:
  - count becomes 3 next clk, ped_pending=1.
  - after A_Y and AR_AB, phase=6 for 5 ticks with walk=1.
  - ped_pending=0 on WALK entry, then phase=3.
- Button pressed during A_G with count=2:
  - count unchanged.
  - WALK is inserted after AR_AB.
- Button held high for 20 cycles, then pressed again during WALK:
  - only one request is latched.
  - the press during WALK leaves ped_pending=0.
  - no second WALK follows.
- green_a=0, yellow_t=0: A_G and A_Y each last exactly 1 tick.
- rst asserted mid B_G with ped_pending=1: next clk phase=5, count=1, ped_pending=0, light_b=100.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared definitions for the semaforo intersection controller: phase encodings,
// lamp patterns, default durations and duration helpers.
package semaforo_pkg;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned LAMP_W  = 3;

    localparam int unsigned DEF_ALLRED_T  = 1;
    localparam int unsigned DEF_WALK_T    = 5;
    localparam int unsigned DEF_MIN_GREEN = 3;

    typedef enum logic [PHASE_W-1:0] {
        S_A_G    = 3'd0,
        S_A_Y    = 3'd1,
        S_AR_AB  = 3'd2,
        S_B_G    = 3'd3,
        S_B_Y    = 3'd4,
        S_AR_BA  = 3'd5,
        S_WALK   = 3'd6,
        S_UNUSED = 3'd7
    } state_e;

    localparam logic [LAMP_W-1:0] RED = 3'b100;
    localparam logic [LAMP_W-1:0] YEL = 3'b010;
    localparam logic [LAMP_W-1:0] GRN = 3'b001;

    // Switch durations of zero run for one tick.
    function automatic logic [CNT_W-1:0] dur4(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    function automatic logic [CNT_W-1:0] dur3(input logic [2:0] v);
        return (v == '0) ? CNT_W'(1) : {1'b0, v};
    endfunction

    function automatic logic [LAMP_W-1:0] lamp_a(input state_e s);
        return (s == S_A_G) ? GRN : (s == S_A_Y) ? YEL : RED;
    endfunction

    function automatic logic [LAMP_W-1:0] lamp_b(input state_e s);
        return (s == S_B_G) ? GRN : (s == S_B_Y) ? YEL : RED;
    endfunction

endpackage

// File: rtl/semaforo_timer.sv
// Loadable phase down-counter; load wins over the tick enable, last flags count==1.
module semaforo_timer
    import semaforo_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = 4'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             last_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_VAL;
            last_q  <= (RST_VAL == CNT_W'(1));
        end else begin
            count_q <= count_d;
            last_q  <= (count_d == CNT_W'(1));
        end
    end

    assign count_o = count_q;
    assign last_o  = last_q;

endmodule

// File: rtl/semaforo_sched.sv
// Phase scheduler for the two-road intersection: A/B green-yellow-allred cycle
// with an inserted pedestrian WALK phase, all timed from the 1 Hz tick.
module semaforo_sched
    import semaforo_pkg::*;
#(
    parameter int unsigned ALLRED_T  = DEF_ALLRED_T,
    parameter int unsigned WALK_T    = DEF_WALK_T,
    parameter int unsigned MIN_GREEN = DEF_MIN_GREEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               ped_btn,
    input  logic [CNT_W-1:0]   green_a,
    input  logic [CNT_W-1:0]   green_b,
    input  logic [2:0]         yellow_t,
    output logic [LAMP_W-1:0]  light_a,
    output logic [LAMP_W-1:0]  light_b,
    output logic               walk,
    output logic               ped_pending,
    output logic [PHASE_W-1:0] phase,
    output logic [CNT_W-1:0]   count
);

    localparam logic [CNT_W-1:0] ALLRED_V = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] WALK_V   = CNT_W'(WALK_T);
    localparam logic [CNT_W-1:0] MING_V   = CNT_W'(MIN_GREEN);

    state_e           state_q, state_d;
    logic             next_b_q, next_b_d;
    logic             pend_q, pend_d;
    logic             btn_q;
    logic             btn_rise_c;
    logic             load_c;
    logic [CNT_W-1:0] load_val_c;
    logic [CNT_W-1:0] count_q;
    logic             last_q;

    assign btn_rise_c = ped_btn & ~btn_q;

    semaforo_timer #(
        .RST_VAL (ALLRED_V)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_c),
        .load_val_i (load_val_c),
        .en_i       (tick),
        .count_o    (count_q),
        .last_o     (last_q)
    );

    // Next phase, counter load and request bookkeeping.
    always_comb begin
        state_d    = state_q;
        load_c     = 1'b0;
        load_val_c = '0;
        next_b_d   = next_b_q;
        pend_d     = pend_q;

        if (state_q == S_AR_AB) next_b_d = 1'b1;
        if (state_q == S_AR_BA) next_b_d = 1'b0;

        if (state_q == S_UNUSED) begin
            state_d    = S_AR_BA;
            load_c     = 1'b1;
            load_val_c = ALLRED_V;
        end else if (tick && last_q) begin
            load_c = 1'b1;
            case (state_q)
                S_A_G: begin
                    state_d    = S_A_Y;
                    load_val_c = dur3(yellow_t);
                end
                S_A_Y: begin
                    state_d    = S_AR_AB;
                    load_val_c = ALLRED_V;
                end
                S_AR_AB: begin
                    state_d    = pend_q ? S_WALK : S_B_G;
                    load_val_c = pend_q ? WALK_V : dur4(green_b);
                end
                S_B_G: begin
                    state_d    = S_B_Y;
                    load_val_c = dur3(yellow_t);
                end
                S_B_Y: begin
                    state_d    = S_AR_BA;
                    load_val_c = ALLRED_V;
                end
                S_AR_BA: begin
                    state_d    = pend_q ? S_WALK : S_A_G;
                    load_val_c = pend_q ? WALK_V : dur4(green_a);
                end
                S_WALK: begin
                    state_d    = next_b_q ? S_B_G : S_A_G;
                    load_val_c = next_b_q ? dur4(green_b) : dur4(green_a);
                end
                default: begin
                    state_d    = S_AR_BA;
                    load_val_c = ALLRED_V;
                end
            endcase
        end else if (btn_rise_c && (state_q == S_A_G || state_q == S_B_G)
                     && (count_q > MING_V)) begin
            load_c     = 1'b1;
            load_val_c = MING_V;
        end

        if (state_d == S_WALK && state_q != S_WALK) begin
            pend_d = 1'b0;
        end else if (btn_rise_c && state_q != S_WALK) begin
            pend_d = 1'b1;
        end
    end

    // Lamps are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_AR_BA;
            next_b_q <= 1'b0;
            pend_q   <= 1'b0;
            btn_q    <= 1'b0;
            light_a  <= RED;
            light_b  <= RED;
            walk     <= 1'b0;
        end else begin
            state_q  <= state_d;
            next_b_q <= next_b_d;
            pend_q   <= pend_d;
            btn_q    <= ped_btn;
            light_a  <= lamp_a(state_d);
            light_b  <= lamp_b(state_d);
            walk     <= (state_d == S_WALK);
        end
    end

    assign phase       = PHASE_W'(state_q);
    assign count       = count_q;
    assign ped_pending = pend_q;

endmodule

// File: tb/tb_semaforo_sched.sv
// Directed self-checking bench for semaforo_sched with default parameters
// (ALLRED_T=1, WALK_T=5, MIN_GREEN=3).
module tb_semaforo_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       ped_btn;
    logic [3:0] green_a;
    logic [3:0] green_b;
    logic [2:0] yellow_t;
    logic [2:0] light_a;
    logic [2:0] light_b;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;
    logic [3:0] count;

    int n_checks = 0;
    int n_errors = 0;

    semaforo_sched dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .ped_btn     (ped_btn),
        .green_a     (green_a),
        .green_b     (green_b),
        .yellow_t    (yellow_t),
        .light_a     (light_a),
        .light_b     (light_b),
        .walk        (walk),
        .ped_pending (ped_pending),
        .phase       (phase),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given tick/button levels; outputs sampled 1 ns after the edge.
    task automatic step(input logic t, input logic b);
        @(negedge clk);
        tick    = t;
        ped_btn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, ped_btn);
            step(1'b0, ped_btn);
        end
    endtask

    function automatic logic [2:0] exp_la(input int p);
        return (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [2:0] exp_lb(input int p);
        return (p == 3) ? 3'b001 : (p == 4) ? 3'b010 : 3'b100;
    endfunction

    int seq_ph [7] = '{5, 0, 1, 2, 3, 4, 5};
    int seq_du [7] = '{1, 4, 2, 1, 6, 2, 1};

    initial begin
        rst      = 1'b1;
        tick     = 1'b0;
        ped_btn  = 1'b0;
        green_a  = 4'd4;
        green_b  = 4'd6;
        yellow_t = 3'd2;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0);

        // Reset state
        check("rst_phase", 32'(phase), 5);
        check("rst_count", 32'(count), 1);
        check("rst_la", 32'(light_a), 4);
        check("rst_lb", 32'(light_b), 4);
        check("rst_walk", 32'(walk), 0);
        check("rst_pend", 32'(ped_pending), 0);

        // Idle cycle: phase sequence and durations
        for (int i = 0; i < 7; i++) begin
            check($sformatf("seq%0d_phase", i), 32'(phase), 32'(seq_ph[i]));
            check($sformatf("seq%0d_count", i), 32'(count), 32'(seq_du[i]));
            check($sformatf("seq%0d_la", i), 32'(light_a), 32'(exp_la(seq_ph[i])));
            check($sformatf("seq%0d_lb", i), 32'(light_b), 32'(exp_lb(seq_ph[i])));
            check($sformatf("seq%0d_walk", i), 32'(walk), 0);
            ticks(seq_du[i]);
        end
        check("seq_end_phase", 32'(phase), 0);
        check("seq_end_count", 32'(count), 4);

        // Press in A_G with count 4 shortens to MIN_GREEN and inserts WALK
        step(1'b0, 1'b1);
        check("short_count", 32'(count), 3);
        check("short_pend", 32'(ped_pending), 1);
        step(1'b0, 1'b0);
        ticks(3);
        check("short_ay", 32'(phase), 1);
        ticks(2);
        check("short_arab", 32'(phase), 2);
        ticks(1);
        check("walk_phase", 32'(phase), 6);
        check("walk_count", 32'(count), 5);
        check("walk_lamp", 32'(walk), 1);
        check("walk_pend", 32'(ped_pending), 0);
        check("walk_la", 32'(light_a), 4);
        check("walk_lb", 32'(light_b), 4);
        ticks(4);
        check("walk_still", 32'(phase), 6);
        ticks(1);
        check("after_walk_phase", 32'(phase), 3);
        check("after_walk_count", 32'(count), 6);
        check("after_walk_walk", 32'(walk), 0);
        ticks(9);
        check("back_ag_phase", 32'(phase), 0);
        check("back_ag_count", 32'(count), 4);

        // Press in A_G with count 2 leaves count alone but still inserts WALK
        ticks(2);
        check("late_pre_count", 32'(count), 2);
        step(1'b0, 1'b1);
        check("late_count", 32'(count), 2);
        check("late_pend", 32'(ped_pending), 1);
        step(1'b0, 1'b0);
        ticks(2 + 2 + 1);
        check("late_walk", 32'(phase), 6);
        ticks(5);
        check("late_bg", 32'(phase), 3);
        check("late_bg_count", 32'(count), 6);

        // Button held 20 cycles in B_G: one request; press in WALK ignored
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        check("held_pend", 32'(ped_pending), 1);
        check("held_count", 32'(count), 3);
        step(1'b0, 1'b0);
        ticks(3 + 2 + 1);
        check("held_walk", 32'(phase), 6);
        check("held_walk_pend", 32'(ped_pending), 0);
        step(1'b0, 1'b1);
        check("inwalk_pend", 32'(ped_pending), 0);
        step(1'b0, 1'b0);
        ticks(5);
        check("held_ag", 32'(phase), 0);
        check("held_ag_count", 32'(count), 4);
        ticks(4 + 2 + 1);
        check("no_2nd_walk", 32'(phase), 3);

        // Zero switch durations run for one tick
        green_a  = 4'd0;
        yellow_t = 3'd0;
        ticks(6);
        check("zero_by_count", 32'(count), 1);
        ticks(2);
        check("zero_ag_phase", 32'(phase), 0);
        check("zero_ag_count", 32'(count), 1);
        check("zero_ag_la", 32'(light_a), 1);
        ticks(1);
        check("zero_ay_phase", 32'(phase), 1);
        check("zero_ay_count", 32'(count), 1);
        check("zero_ay_la", 32'(light_a), 2);
        ticks(1);
        check("zero_arab", 32'(phase), 2);
        green_a  = 4'd4;
        yellow_t = 3'd2;
        ticks(1);
        check("zero_bg", 32'(phase), 3);

        // Reset mid B_G with a pending request
        step(1'b0, 1'b1);
        check("mrst_pre_pend", 32'(ped_pending), 1);
        step(1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        check("mrst_phase", 32'(phase), 5);
        check("mrst_count", 32'(count), 1);
        check("mrst_pend", 32'(ped_pending), 0);
        check("mrst_lb", 32'(light_b), 4);
        check("mrst_la", 32'(light_a), 4);
        ticks(1);
        check("mrst_ag", 32'(phase), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
